// File: rtl/sprite_write_sink_if.sv
// Store bus from the stack machine into the sprite window.
// One store per cycle while write is high; no backpressure.
interface sprite_write_sink_if;
  logic        write;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;

  modport master (
    output write,
    output wr_addr,
    output wr_data
  );

  modport slave (
    input write,
    input wr_addr,
    input wr_data
  );
endinterface

// File: rtl/sprite_write_sink.sv
// Sprite attribute sink: buffers window stores in a FIFO and
// commits them to the active table only during vblank.
module sprite_write_sink #(
  parameter int          NUM_SPRITES = 8,
  parameter logic [15:0] BASE_ADDR   = 16'h0100,
  parameter int          FIFO_DEPTH  = 4,
  localparam int         AW = $clog2(4*NUM_SPRITES)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  sprite_write_sink_if.slave   bus,
  input  logic                 vblank,
  input  logic [AW-1:0]        rd_addr,
  output logic [15:0]          rd_data,
  output logic                 pending,
  output logic                 overflow,
  input  logic                 clr_overflow,
  output logic                 frame_done
);

  localparam int NW = 4*NUM_SPRITES;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [16:0] LIMIT =
    {1'b0, BASE_ADDR} + 17'(NW);

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [15:0]   data;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    DONE
  } state_t;

  state_t        state, state_nx;
  logic          fd_nx;

  entry_t        fifo [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count, count_nx;

  logic [15:0]   active [NW];

  logic          hit, full, empty;
  logic          push, pop, drop;
  entry_t        in_ent, head;

  assign hit = bus.write
            && (bus.wr_addr >= BASE_ADDR)
            && ({1'b0, bus.wr_addr} < LIMIT);

  assign in_ent.idx  = AW'(bus.wr_addr - BASE_ADDR);
  assign in_ent.data = bus.wr_data;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign head  = fifo[rptr];

  // A pop frees a slot on the same edge, so a hit while full
  // is still accepted when the drain is popping.
  assign pop  = (state == DRAIN) && !empty;
  assign push = hit && (!full || pop);
  assign drop = hit && full && !pop;

  assign pending = !empty;

  // Occupancy after this edge's push/pop.
  always_comb begin
    count_nx = count;
    if (push && !pop)
      count_nx = count + CW'(1);
    else if (pop && !push)
      count_nx = count - CW'(1);
  end

  // FIFO storage and pointers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        fifo[i] <= '0;
    end else begin
      if (push) begin
        fifo[wptr] <= in_ent;
        wptr       <= wptr + PW'(1);
      end
      if (pop)
        rptr <= rptr + PW'(1);
      count <= count_nx;
    end
  end

  // Active table: head entry commits on each pop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NW; i++)
        active[i] <= '0;
    end else if (pop) begin
      active[head.idx] <= head.data;
    end
  end

  // Scanner read port, read-before-write against commits.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      rd_data <= '0;
    else
      rd_data <= active[rd_addr];
  end

  // Sticky drop flag; a new drop beats a clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      overflow <= 1'b0;
    else if (drop)
      overflow <= 1'b1;
    else if (clr_overflow)
      overflow <= 1'b0;
  end

  // State and frame_done registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      frame_done <= fd_nx;
    end
  end

  // Next state; frame_done fires on the DRAIN->DONE step.
  always_comb begin
    state_nx = state;
    fd_nx    = 1'b0;
    unique case (state)
      IDLE: begin
        if (vblank)
          state_nx = DRAIN;
      end
      DRAIN: begin
        if (!vblank) begin
          state_nx = IDLE;
        end else if (count_nx == '0) begin
          state_nx = DONE;
          fd_nx    = 1'b1;
        end
      end
      DONE: begin
        if (!vblank)
          state_nx = IDLE;
        else if (hit)
          state_nx = DRAIN;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: doc/sprite_write_sink.md
Name: sprite_write_sink

Overview:
- Write-side responder for the stack machine's memory-store port. It sits on the `write`/`wr_addr`/`wr_data` bus and decodes stores aimed at the sprite attribute window.
- Decoded stores are buffered in a small FIFO and committed to the active sprite attribute table only while `vblank` is high, so sprites never tear mid-frame.
- The video scanner reads the active table through a registered read port.

Parameters:
- NUM_SPRITES, 8, number of sprites; each sprite owns 4 consecutive 16-bit words: x, y, tile, attr.
- BASE_ADDR, 16'h0100, first address of the sprite window; window is BASE_ADDR .. BASE_ADDR+4*NUM_SPRITES-1.
- FIFO_DEPTH, 4, pending-write buffer entries; must be a power of two, ≥2.

Ports:
- clock  input  1  single system clock; all state on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- write  input  1  store strobe from the stack machine; one store per high cycle; no backpressure.
- wr_addr  input  16  store address.
- wr_data  input  16  store data.
- vblank  input  1  high during vertical blanking; commits permitted only while high.
- rd_addr  input  log2(4*NUM_SPRITES)  scanner read index into the active table.
- rd_data  output  16  registered read data.
- pending  output  1  FIFO non-empty.
- overflow  output  1  sticky: a hit store was dropped because the FIFO was full.
- clr_overflow  input  1  synchronous clear of overflow.
- frame_done  output  1  one-cycle pulse when the FIFO empties during vblank.

Behaviour:
- Reset (reset_n low, asynchronous): active table all 0; FIFO empty; rd_data=0; overflow=0; frame_done=0; pending=0; state=IDLE. Reset asserted mid-drain aborts the drain and discards the FIFO contents.
- Decode: hit = write && BASE_ADDR <= wr_addr < BASE_ADDR+4*NUM_SPRITES (16-bit unsigned compare). Index = wr_addr - BASE_ADDR, truncated to the rd_addr width.
  - Misses are ignored with no side effects.
  - A write with wr_addr = BASE_ADDR+4*NUM_SPRITES is a miss.
- Push: a hit enqueues {index, wr_data} on the same rising edge.
- Pop:
  - Occurs when state=DRAIN and the FIFO is non-empty.
  - Head entry is written to active[index] on that edge.
  - Throughput is one entry per cycle; order is strict FIFO.
  - Duplicate indices are each applied in order, so the last one wins.
- Full handling:
  - Hit while full with no pop in that cycle: store dropped, overflow <= 1.
  - Hit while full with a simultaneous pop: store accepted, no overflow.
  - Hit while empty in DRAIN: enqueued, popped no earlier than the next cycle.
- Overflow register: clr_overflow clears it. If clr_overflow and a new drop occur in the same cycle, overflow is 1 (set wins).
- Pointers wrap modulo FIFO_DEPTH. Occupancy counter spans 0..FIFO_DEPTH; pending = (count != 0).
- State machine:
  - IDLE: vblank=0. On vblank=1, go to DRAIN.
  - DRAIN: pop each cycle while non-empty.
    - vblank falls: go to IDLE; remaining entries are held for the next vblank.
    - FIFO becomes empty (count reaches 0 after a pop, or is 0 on entry): go to DONE and assert frame_done for exactly one cycle.
  - DONE: no pops.
    - New hit arrives while vblank=1: go back to DRAIN. frame_done pulses again when that drain empties.
    - vblank falls: go to IDLE.
- Read port:
  - rd_data <= active[rd_addr] every cycle; latency is 1 clock.
  - If a pop writes the same index in the same cycle, rd_data returns the old value (read-before-write).

Test Plan:
- Reset, then read index 0..31 -> rd_data=0 for all; overflow=0, pending=0, frame_done=0.
- vblank=0; write 16'h0105 <= 16'h00AA -> pending=1, active[5] still 0. Raise vblank -> active[5]=16'h00AA one cycle after DRAIN entry; frame_done pulses once; pending=0.
- Writes to 16'h00FF, 16'h0120, 16'h2000 -> all ignored; pending stays 0.
- vblank=0; 5 hits to indices 0..4 with data 1..5 -> first 4 queued, overflow=1. In vblank, active[0..3]=1..4, active[4]=0. Pulse clr_overflow -> overflow=0.
- FIFO full, vblank=1: hit on the same edge as a pop -> accepted, overflow stays 0. Then 3 entries queued with vblank dropped after 1 pop -> 2 entries remain, pending=1; they commit on the next vblank.
- Two writes to index 7 (16'h1111, then 16'h2222) -> after drain active[7]=16'h2222. Reading index 7 on the pop cycle of 16'h2222 -> rd_data=16'h1111, then 16'h2222 the following cycle.
